// File: rtl/ifu_pkg.sv
// Shared IFU instruction-cache types and constants, plus the refill sequencer
// state encoding and beat geometry.
package ifu_pkg;

    localparam int unsigned NUM_TAGS      = 16;
    localparam int unsigned TAG_WIDTH     = 27;
    localparam int unsigned OFFSET_WIDTH  = 5;
    localparam int unsigned LINE_WIDTH    = 128;
    localparam int unsigned P_BITS        = $clog2(NUM_TAGS);
    localparam int unsigned BEAT_WIDTH    = 32;
    localparam int unsigned NUM_BEATS     = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned BEAT_CNT_BITS = $clog2(NUM_BEATS);

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
    } tag_arr_t;

    typedef logic [LINE_WIDTH-1:0] data_arr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RECV,
        ST_FILL,
        ST_FLUSH
    } refill_state_t;

    localparam logic [OFFSET_WIDTH-1:0] LINE_BASE_OFFSET = '0;

    function automatic logic [31:0] line_base(input logic [TAG_WIDTH-1:0] tag);
        return {tag, LINE_BASE_OFFSET};
    endfunction

endpackage

// File: rtl/ifu_line_assembler.sv
// Collects memory response beats into a full cache line; beat k lands in
// line[32k +: 32] and line_done flags the beat that completes the line.
module ifu_line_assembler
    import ifu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  beat_valid,
    input  logic [BEAT_WIDTH-1:0] beat_data,
    output data_arr_t             line,
    output data_arr_t             line_next,
    output logic                  line_done
);

    logic [BEAT_CNT_BITS-1:0] cnt;

    always_comb begin
        line_next = line;
        for (int unsigned k = 0; k < NUM_BEATS; k++) begin
            if (beat_valid && (cnt == BEAT_CNT_BITS'(k))) begin
                line_next[k*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
            end
        end
    end

    assign line_done = beat_valid && (cnt == BEAT_CNT_BITS'(NUM_BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            line <= '0;
        end else begin
            line <= line_next;
            if (clear) begin
                cnt <= '0;
            end else if (beat_valid) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifu_refill_ctrl.sv
// IFU miss/refill sequencer: fetches a 4-beat line, writes it into a
// round-robin victim slot, and sequences full-cache invalidation.
module ifu_refill_ctrl
    import ifu_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  MissValid,
    input  logic [31:0]           MissAddr,
    output logic                  MissReady,
    input  logic                  FlushReq,
    output logic                  MemReqValid,
    output logic [31:0]           MemReqAddr,
    input  logic                  MemReqReady,
    input  logic                  MemRspValid,
    input  logic [BEAT_WIDTH-1:0] MemRspData,
    output logic                  TagWrEn,
    output logic [P_BITS-1:0]     TagWrIdx,
    output tag_arr_t              TagWrEntry,
    output logic                  DataWrEn,
    output logic [P_BITS-1:0]     DataWrIdx,
    output data_arr_t             DataWrLine,
    output logic                  FillDone,
    output logic                  Busy
);

    refill_state_t        state;
    logic [P_BITS-1:0]    victim;
    logic [P_BITS-1:0]    flush_idx;
    logic                 flush_pending;
    logic [TAG_WIDTH-1:0] miss_tag;

    logic      asm_clear;
    logic      asm_beat;
    data_arr_t asm_line;
    data_arr_t asm_line_next;
    logic      asm_done;

    assign asm_clear = (state == ST_REQ) && MemReqReady;
    assign asm_beat  = (state == ST_RECV) && MemRspValid;

    ifu_line_assembler u_asm (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .clear      (asm_clear),
        .beat_valid (asm_beat),
        .beat_data  (MemRspData),
        .line       (asm_line),
        .line_next  (asm_line_next),
        .line_done  (asm_done)
    );

    assign MissReady = ~Busy;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state         <= ST_IDLE;
            victim        <= '0;
            flush_idx     <= '0;
            flush_pending <= 1'b0;
            miss_tag      <= '0;
            MemReqValid   <= 1'b0;
            MemReqAddr    <= '0;
            TagWrEn       <= 1'b0;
            TagWrIdx      <= '0;
            TagWrEntry    <= '0;
            DataWrEn      <= 1'b0;
            DataWrIdx     <= '0;
            DataWrLine    <= '0;
            FillDone      <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            TagWrEn  <= 1'b0;
            DataWrEn <= 1'b0;
            FillDone <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Flush takes priority; a coincident miss is left for the requester to re-present.
                    if (FlushReq || flush_pending) begin
                        state         <= ST_FLUSH;
                        flush_pending <= 1'b0;
                        flush_idx     <= '0;
                        TagWrEn       <= 1'b1;
                        TagWrIdx      <= '0;
                        TagWrEntry    <= '0;
                        Busy          <= 1'b1;
                    end else if (MissValid) begin
                        state       <= ST_REQ;
                        miss_tag    <= MissAddr[31:OFFSET_WIDTH];
                        MemReqValid <= 1'b1;
                        MemReqAddr  <= line_base(MissAddr[31:OFFSET_WIDTH]);
                        Busy        <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (FlushReq) begin
                        flush_pending <= 1'b1;
                    end
                    if (MemReqReady) begin
                        MemReqValid <= 1'b0;
                        state       <= ST_RECV;
                    end
                end

                ST_RECV: begin
                    if (FlushReq) begin
                        flush_pending <= 1'b1;
                    end
                    if (asm_done) begin
                        state      <= ST_FILL;
                        TagWrEn    <= 1'b1;
                        DataWrEn   <= 1'b1;
                        TagWrIdx   <= victim;
                        DataWrIdx  <= victim;
                        TagWrEntry <= '{valid: 1'b1, tag: miss_tag};
                        DataWrLine <= asm_line_next;
                        FillDone   <= 1'b1;
                    end
                end

                ST_FILL: begin
                    victim <= victim + 1'b1;
                    if (flush_pending) begin
                        state         <= ST_FLUSH;
                        flush_pending <= 1'b0;
                        flush_idx     <= '0;
                        TagWrEn       <= 1'b1;
                        TagWrIdx      <= '0;
                        TagWrEntry    <= '0;
                    end else begin
                        // A flush arriving now is held and picked up from IDLE.
                        flush_pending <= FlushReq;
                        state         <= ST_IDLE;
                        Busy          <= 1'b0;
                    end
                end

                ST_FLUSH: begin
                    if (flush_idx == P_BITS'(NUM_TAGS - 1)) begin
                        state  <= ST_IDLE;
                        victim <= '0;
                        Busy   <= 1'b0;
                    end else begin
                        flush_idx  <= flush_idx + 1'b1;
                        TagWrEn    <= 1'b1;
                        TagWrIdx   <= flush_idx + 1'b1;
                        TagWrEntry <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_refill_ctrl.sv
// Directed bench for ifu_refill_ctrl: expected array writes are queued as
// stimulus is driven and checked against the DUT's write strobes.
module tb_ifu_refill_ctrl;
    import ifu_pkg::*;

    logic            Clk;
    logic            Rst_n;
    logic            MissValid;
    logic [31:0]     MissAddr;
    logic            MissReady;
    logic            FlushReq;
    logic            MemReqValid;
    logic [31:0]     MemReqAddr;
    logic            MemReqReady;
    logic            MemRspValid;
    logic [31:0]     MemRspData;
    logic            TagWrEn;
    logic [3:0]      TagWrIdx;
    tag_arr_t        TagWrEntry;
    logic            DataWrEn;
    logic [3:0]      DataWrIdx;
    data_arr_t       DataWrLine;
    logic            FillDone;
    logic            Busy;

    ifu_refill_ctrl dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .MissValid   (MissValid),
        .MissAddr    (MissAddr),
        .MissReady   (MissReady),
        .FlushReq    (FlushReq),
        .MemReqValid (MemReqValid),
        .MemReqAddr  (MemReqAddr),
        .MemReqReady (MemReqReady),
        .MemRspValid (MemRspValid),
        .MemRspData  (MemRspData),
        .TagWrEn     (TagWrEn),
        .TagWrIdx    (TagWrIdx),
        .TagWrEntry  (TagWrEntry),
        .DataWrEn    (DataWrEn),
        .DataWrIdx   (DataWrIdx),
        .DataWrLine  (DataWrLine),
        .FillDone    (FillDone),
        .Busy        (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic         data_en;
        logic [3:0]   idx;
        logic         valid;
        logic [26:0]  tag;
        logic [127:0] line;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         fill_cyc = 0;
    logic [3:0] victim_model = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (TagWrEn || DataWrEn) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {TagWrEn, DataWrEn}, 0);
            end else begin
                e = sb.pop_front();
                check("wr_tag_en", TagWrEn, 1);
                check("wr_data_en", DataWrEn, e.data_en);
                check("wr_tag_idx", TagWrIdx, e.idx);
                check("wr_entry", TagWrEntry, {e.valid, e.tag});
                check("fill_done", FillDone, e.data_en);
                if (e.data_en) begin
                    check("wr_data_idx", DataWrIdx, e.idx);
                    check("wr_line", DataWrLine, e.line);
                    fill_cyc = cyc;
                end
            end
        end else begin
            check("stray_fill_done", FillDone, 0);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic push_flush();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.data_en = 1'b0;
            e.idx     = 4'(i);
            e.valid   = 1'b0;
            e.tag     = '0;
            e.line    = '0;
            sb.push_back(e);
        end
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [127:0] line,
                           input int req_wait, input int gap, input int flush_beat);
        exp_t        e;
        int          acc_cyc;
        logic [31:0] beat;
        check("miss_ready_idle", MissReady, 1);
        e.data_en = 1'b1;
        e.idx     = victim_model;
        e.valid   = 1'b1;
        e.tag     = addr[31:5];
        e.line    = line;
        sb.push_back(e);
        victim_model = victim_model + 4'd1;
        acc_cyc   = cyc;
        MissValid = 1'b1;
        MissAddr  = addr;
        step();
        MissValid = 1'b0;
        MissAddr  = $urandom;
        check("req_valid", MemReqValid, 1);
        check("req_addr", MemReqAddr, {addr[31:5], 5'b0});
        check("miss_ready_busy", MissReady, 0);
        for (int w = 0; w < req_wait; w++) begin
            MemRspValid = 1'b1;
            MemRspData  = 32'hDEAD_BEEF;
            step();
            check("req_valid_hold", MemReqValid, 1);
            check("req_addr_hold", MemReqAddr, {addr[31:5], 5'b0});
        end
        MemRspValid = 1'b0;
        MemReqReady = 1'b1;
        step();
        MemReqReady = 1'b0;
        check("req_valid_drop", MemReqValid, 0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                step();
                check("recv_busy", MissReady, 0);
            end
            beat        = line[k*32 +: 32];
            MemRspValid = 1'b1;
            MemRspData  = beat;
            if (k == flush_beat) begin
                FlushReq = 1'b1;
                push_flush();
            end
            step();
            MemRspValid = 1'b0;
            FlushReq    = 1'b0;
        end
        check("fill_latency", fill_cyc - acc_cyc, 6 + req_wait + 4*gap);
        step();
    endtask

    initial begin
        logic [127:0] ln;
        Rst_n       = 1'b0;
        MissValid   = 1'b0;
        MissAddr    = '0;
        FlushReq    = 1'b0;
        MemReqReady = 1'b0;
        MemRspValid = 1'b0;
        MemRspData  = '0;
        step();
        step();
        check("rst_miss_ready", MissReady, 1);
        check("rst_busy", Busy, 0);
        check("rst_req_valid", MemReqValid, 0);
        check("rst_req_addr", MemReqAddr, 0);
        check("rst_tag_wr", TagWrEn, 0);
        check("rst_data_wr", DataWrEn, 0);
        check("rst_line", DataWrLine, 0);
        Rst_n = 1'b1;
        step();

        // Basic miss with ready memory.
        do_miss(32'h0000_1234, 128'h44444444_33333333_22222222_11111111, 0, 0, -1);
        check("s1_idle", Busy, 0);

        // Flush and miss in the same IDLE cycle: flush wins.
        push_flush();
        FlushReq  = 1'b1;
        MissValid = 1'b1;
        MissAddr  = 32'hABCD_0040;
        step();
        FlushReq  = 1'b0;
        MissValid = 1'b0;
        check("collide_no_req", MemReqValid, 0);
        check("collide_busy", Busy, 1);
        for (int i = 0; i < 15; i++) step();
        step();
        check("flush_done_ready", MissReady, 1);
        check("flush_done_wr", TagWrEn, 0);
        victim_model = '0;

        // 17 back-to-back misses wrap the victim pointer.
        for (int m = 0; m < 17; m++) begin
            ln = {$urandom, $urandom, $urandom, $urandom};
            do_miss({$urandom_range(0, 32'h7FFF_FFFF), 1'b0}, ln, 0, 0, -1);
        end

        // Stalled request, stray beats while waiting, gapped response beats.
        do_miss(32'hFEDC_BA98, 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0, 5, 3, -1);

        // Flush arriving mid-refill runs after the fill.
        do_miss(32'h2000_0010, 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA, 0, 1, 2);
        check("s5_flushing", Busy, 1);
        for (int i = 0; i < 15; i++) step();
        step();
        check("s5_idle", Busy, 0);
        victim_model = '0;

        // Put the pointer off zero, then reset mid-refill.
        do_miss(32'h0000_0100, 128'h1, 0, 0, -1);
        MissValid = 1'b1;
        MissAddr  = 32'h7777_7777;
        step();
        MissValid   = 1'b0;
        MemReqReady = 1'b1;
        step();
        MemReqReady = 1'b0;
        for (int k = 0; k < 2; k++) begin
            MemRspValid = 1'b1;
            MemRspData  = 32'h1234_0000 + 32'(k);
            step();
        end
        MemRspValid = 1'b0;
        Rst_n = 1'b0;
        step();
        check("midrst_ready", MissReady, 1);
        check("midrst_busy", Busy, 0);
        check("midrst_req", MemReqValid, 0);
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            MemRspValid = 1'b1;
            MemRspData  = 32'hBAAD_F00D;
            step();
            check("stray_rsp_idle", Busy, 0);
        end
        MemRspValid = 1'b0;
        victim_model = '0;
        do_miss(32'h0BAD_BEE0, 128'h99999999_88888888_77777777_66666666, 1, 2, -1);

        step();
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_refill_ctrl.md
Name: ifu_refill_ctrl

Overview:
Miss/refill sequencer for the IFU instruction cache's fully-associative tag and data arrays (16 entries, 27-bit tag, 128-bit line). It accepts one miss at a time and fetches the line from memory as four 32-bit beats. It then writes the tag entry and data line into a round-robin victim slot. It also sequences a full-cache invalidate (flush) and sits between the IFU hit/miss lookup logic and the memory read port.

Parameters:
NUM_TAGS, 16, entries in tag/data arrays (from ifu_pkg)
TAG_WIDTH, 27, tag bits = addr[31:5] (from ifu_pkg)
OFFSET_WIDTH, 5, line-offset bits (from ifu_pkg)
LINE_WIDTH, 128, line width (from ifu_pkg)
BEAT_WIDTH, 32, memory response width; NUM_BEATS = LINE_WIDTH/BEAT_WIDTH = 4
P_BITS, 4, $clog2(NUM_TAGS) (from ifu_pkg)

Ports:
Clk  in  1  clock
Rst_n  in  1  reset, synchronous active-low
MissValid  in  1  lookup missed, MissAddr valid
MissAddr  in  32  missing fetch address
MissReady  out  1  controller idle and can accept a miss
FlushReq  in  1  single-cycle pulse: invalidate all entries
MemReqValid  out  1  line read request valid
MemReqAddr  out  32  line base address {tag, 5'b0}
MemReqReady  in  1  memory accepts request
MemRspValid  in  1  response beat valid
MemRspData  in  32  response beat
TagWrEn  out  1  tag array write strobe
TagWrIdx  out  P_BITS  tag array write index
TagWrEntry  out  tag_arr_t  {valid, tag} to write
DataWrEn  out  1  data array write strobe
DataWrIdx  out  P_BITS  data array write index
DataWrLine  out  data_arr_t  assembled line
FillDone  out  1  one-cycle pulse: refill written
Busy  out  1  state != IDLE

Behaviour:
- Reset (Rst_n=0 at posedge): state IDLE; victim ptr=0; beat cnt=0; flush-pending=0; line buffer=0. All outputs 0 except MissReady=1. Reset mid-refill or mid-flush aborts with no further array writes.
- States: IDLE, REQ, RECV, FILL, FLUSH.
- IDLE: MissReady=1.
  - FlushReq or flush-pending -> FLUSH; flush wins over a simultaneous MissValid, and the miss is not accepted (MissReady stays 1 only that cycle; the requester re-presents it).
  - Else MissValid -> latch tag=MissAddr[31:5], go to REQ.
- REQ: MemReqValid=1, MemReqAddr={tag,5'b0}, held stable until MemReqReady=1 in the same cycle, then go to RECV with beat cnt=0.
- RECV: on each MemRspValid, beat k is stored into line[32k+31:32k] and cnt increments. Gaps are allowed. The beat with cnt==3 completes the line; next state FILL.
- FILL (exactly 1 cycle):
  - TagWrEn=DataWrEn=1; TagWrIdx=DataWrIdx=victim ptr; TagWrEntry={1'b1,tag}; DataWrLine=line; FillDone=1.
  - Victim ptr increments, wrapping 15->0.
  - Next state FLUSH if flush-pending, else IDLE.
- Miss-to-fill latency with ready memory: accept cycle T, MemReqValid T+1, beats T+2..T+5 minimum, FILL T+6.
- MemRspValid outside RECV is ignored.
- FlushReq arriving in REQ/RECV/FILL sets sticky flush-pending. The in-flight refill completes first, then flush runs. Pending is cleared on entering FLUSH.
- FLUSH: one entry per cycle, idx 0..15. TagWrEn=1, TagWrEntry={1'b0, '0}, DataWrEn=0. Lasts 16 cycles, then IDLE with victim ptr=0. FlushReq during FLUSH is absorbed (no restart).
- Busy=1 in all states except IDLE. MissReady=~Busy.

Decomposition:
- ifu_pkg additions: BEAT_WIDTH, NUM_BEATS, a refill state enum typedef, and a helper constant for the line-base zero offset. tag_arr_t and data_arr_t are reused unchanged.
- One natural sub-module: ifu_line_assembler (beat counter + 128-bit shift/insert buffer, outputs line_done).

Test Plan:
- Single miss, MissAddr=0x0000_1234, MemReqReady=1, beats 0x11111111..0x44444444 -> MemReqAddr=0x0000_1220; FILL at idx 0 with tag=0x91, line=0x44444444_33333333_22222222_11111111; FillDone 1 cycle.
- 17 back-to-back misses -> fills at idx 0..15, the 17th at idx 0 (wrap); MissReady=0 throughout each refill.
- MemReqReady held low 5 cycles -> MemReqValid/Addr stable; no RECV entry until ready; beats with 3-cycle gaps still assemble correctly.
- FlushReq and MissValid in the same IDLE cycle -> 16 TagWrEn cycles idx 0..15 with valid=0; miss not taken; ptr=0 afterwards.
- FlushReq during RECV beat 2 -> refill completes (FillDone), then 16-cycle flush, then IDLE.
- Rst_n low during RECV after 2 beats -> no TagWrEn/DataWrEn; IDLE, MissReady=1, ptr=0; stray MemRspValid afterwards is ignored.
